// File: rtl/imm_gen_pipe.sv
// RV immediate generator (I/S/B/U/J + CSR zimm) with a registered output stage
// and a one-entry skid so in_ready_o never depends combinationally on out_ready_i.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int ERR_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [2:0]       fmt_i,
   input  logic             zext_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic             fmt_err_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic            err;
   } ent_t;

   ent_t             w_dec;
   ent_t             r_out;
   ent_t             r_skid;
   logic             r_out_vld;
   logic             r_skid_vld;
   logic [ERR_W-1:0] r_err_cnt;
   logic             w_s;
   logic             w_se;
   logic             w_accept;
   logic             w_deliver;
   logic             w_out_free;

   assign w_s  = instr_i[31];
   assign w_se = w_s & ~zext_i;

   always_comb begin
      w_dec = '0;
      case (fmt_i)
         3'd0: w_dec.imm = {{(XLEN-12){w_se}}, instr_i[31:20]};
         3'd1: w_dec.imm = {{(XLEN-12){w_se}}, instr_i[31:25], instr_i[11:7]};
         3'd2: w_dec.imm = {{(XLEN-13){w_s}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
         3'd3: w_dec.imm = {{(XLEN-32){w_s}}, instr_i[31:12], 12'b0};
         3'd4: w_dec.imm = {{(XLEN-21){w_s}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
         3'd5: w_dec.imm = {{(XLEN-5){1'b0}}, instr_i[19:15]};
         default: w_dec.err = 1'b1;
      endcase
   end

   assign w_accept   = in_valid_i & ~r_skid_vld;
   assign w_deliver  = r_out_vld & out_ready_i;
   assign w_out_free = ~r_out_vld | out_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
      end else if (flush_i) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (r_skid_vld) begin
         // skid full implies in_ready_o=0, so no accept can race this drain
         if (w_deliver) begin
            r_out      <= r_skid;
            r_out_vld  <= 1'b1;
            r_skid_vld <= 1'b0;
         end
      end else if (w_accept) begin
         if (w_out_free) begin
            r_out     <= w_dec;
            r_out_vld <= 1'b1;
         end else begin
            r_skid     <= w_dec;
            r_skid_vld <= 1'b1;
         end
      end else if (w_deliver) begin
         r_out_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_err_cnt <= '0;
      else if (w_accept && w_dec.err && (r_err_cnt != {ERR_W{1'b1}}))
         r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign in_ready_o  = ~r_skid_vld;
   assign out_valid_o = r_out_vld;
   assign imm_o       = r_out.imm;
   assign fmt_err_o   = r_out.err;
   assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode formats, backpressure, flush, reset, saturation.
module tb_imm_gen_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  fmt = '0;
   logic        zext = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, fmt_err;
   logic [31:0] imm;
   logic [7:0]  err_cnt;
   logic        in_ready64, out_valid64, fmt_err64;
   logic [63:0] imm64;
   logic [7:0]  err_cnt64;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .ERR_W(8)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .instr_i(instr), .fmt_i(fmt), .zext_i(zext),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .imm_o(imm),
      .fmt_err_o(fmt_err), .err_cnt_o(err_cnt));

   imm_gen_pipe #(.XLEN(64), .ERR_W(8)) u_dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready64), .instr_i(instr), .fmt_i(fmt), .zext_i(zext),
      .out_valid_o(out_valid64), .out_ready_i(out_ready), .imm_o(imm64),
      .fmt_err_o(fmt_err64), .err_cnt_o(err_cnt64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] i, input logic [2:0] f, input logic z);
      in_valid = 1'b1;
      instr    = i;
      fmt      = f;
      zext     = z;
   endtask

   initial begin
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_imm", imm, 0);
      chk("rst_fmt_err", fmt_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b1;
      cyc();

      // formats
      out_ready = 1'b1;
      drive(32'hFFF00093, 3'd0, 1'b0); cyc();
      chk("I_valid", out_valid, 1);
      chk("I_sext", imm, 64'hFFFFFFFF);
      chk("I_err", fmt_err, 0);
      drive(32'hFFF00093, 3'd0, 1'b1); cyc();
      chk("I_zext", imm, 64'h00000FFF);
      drive(32'hFE20AE23, 3'd1, 1'b0); cyc();
      chk("S", imm, 64'hFFFFFFFC);
      drive(32'hFE000EE3, 3'd2, 1'b1); cyc();
      chk("B_zext_ignored", imm, 64'hFFFFFFFC);
      drive(32'h12345037, 3'd3, 1'b0); cyc();
      chk("U", imm, 64'h12345000);
      drive(32'hFF9FF06F, 3'd4, 1'b0); cyc();
      chk("J", imm, 64'hFFFFFFF8);
      chk("J64", imm64, 64'hFFFFFFFFFFFFFFF8);
      drive(32'h000F8073, 3'd5, 1'b0); cyc();
      chk("Z", imm, 64'h0000001F);
      drive(32'h80000037, 3'd3, 1'b0); cyc();
      chk("U64", imm64, 64'hFFFFFFFF80000000);
      chk("U32", imm, 64'h80000000);
      in_valid = 1'b0; cyc();
      chk("drained", out_valid, 0);

      // backpressure
      out_ready = 1'b0;
      drive(32'h00001037, 3'd3, 1'b0); cyc();
      chk("bp_A_out", imm, 64'h00001000);
      chk("bp_A_rdy", in_ready, 1);
      drive(32'h00002037, 3'd3, 1'b0); cyc();
      chk("bp_B_held_A", imm, 64'h00001000);
      chk("bp_B_rdy", in_ready, 0);
      drive(32'h00003037, 3'd3, 1'b0); cyc();
      chk("bp_C_held_A", imm, 64'h00001000);
      chk("bp_C_valid", out_valid, 1);
      chk("bp_C_rdy", in_ready, 0);
      out_ready = 1'b1; cyc();
      chk("bp_out_B", imm, 64'h00002000);
      chk("bp_rdy_back", in_ready, 1);
      cyc();
      chk("bp_out_C", imm, 64'h00003000);
      in_valid = 1'b0; cyc();
      chk("bp_empty", out_valid, 0);

      // flush with two buffered
      out_ready = 1'b0;
      drive(32'h00004037, 3'd3, 1'b0); cyc();
      drive(32'h00005037, 3'd3, 1'b0); cyc();
      chk("fl_pre_rdy", in_ready, 0);
      in_valid = 1'b0; flush = 1'b1; cyc();
      flush = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_rdy", in_ready, 1);
      cyc();
      chk("fl_stays_empty", out_valid, 0);

      // async reset with two buffered
      drive(32'h00006037, 3'd3, 1'b0); cyc();
      drive(32'h00007037, 3'd3, 1'b0); cyc();
      in_valid = 1'b0;
      chk("ar_pre_valid", out_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_imm", imm, 0);
      chk("ar_rdy", in_ready, 1);
      #1 rst = 1'b1;
      cyc();
      chk("ar_after", out_valid, 0);

      // illegal format saturation
      out_ready = 1'b1;
      drive(32'hFFFFFFFF, 3'd7, 1'b0);
      for (int i = 0; i < 300; i++) begin
         cyc();
         chk("ill_imm", imm, 0);
         chk("ill_err", fmt_err, 1);
         chk("ill_cnt", err_cnt, (i < 254) ? i + 1 : 255);
      end
      chk("ill_cnt64", err_cnt64, 8'hFF);
      drive(32'hFFFFFFFF, 3'd6, 1'b0); cyc();
      chk("ill6_err", fmt_err, 1);
      chk("ill6_sat", err_cnt, 8'hFF);
      drive(32'h00100093, 3'd0, 1'b0); cyc();
      chk("legal_err", fmt_err, 0);
      chk("legal_imm", imm, 64'h1);
      in_valid = 1'b0; flush = 1'b1; cyc();
      flush = 1'b0;
      chk("flush_keeps_cnt", err_cnt, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
